// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the main-memory data-port arbiter.
//   ReadWriteModes : access mode encoding on the memory pins (3'h6/3'h7 are illegal)
//   ArbState       : arbiter FSM states
//   ArbOwner       : which requester owns the current-cycle transfer
//   mem_req_t      : one requester's request fields, as forwarded to memory
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        NONE      = 3'h0,
        BYTE      = 3'h1,
        HALFWORD  = 3'h2,
        WORD      = 3'h3,
        WORDLEFT  = 3'h4,
        WORDRIGHT = 3'h5
    } ReadWriteModes;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_YIELD  = 2'd2
    } ArbState;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } ArbOwner;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [2:0]  write_mode;
        logic [2:0]  read_mode;
        logic        unsigned_load;
    } mem_req_t;

    // Encodings above WORDRIGHT have no meaning to the memory.
    function automatic logic is_illegal_mode(input logic [2:0] mode);
        return mode > 3'h5;
    endfunction

endpackage

// File: rtl/mem_arb_lock_timer.sv
// Counts consecutive cycles the CPU has been kept waiting by a loader lock.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : zero the count (CPU not waiting, or lock not in force)
//   inc       : CPU waited this cycle; count saturates at MAX_LOCK_CYCLES-1
//   expire    : this cycle's wait brings the count to MAX_LOCK_CYCLES-1,
//               so the arbiter must hand the next cycle to the CPU
module mem_arb_lock_timer #(
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(MAX_LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK_CYCLES - 2);

    logic [CNT_W-1:0] lock_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_cnt <= '0;
        end else if (clear) begin
            lock_cnt <= '0;
        end else if (inc && lock_cnt != CNT_MAX) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
        end
    end

    // Looks at the value the count is about to take, so the yield is
    // scheduled in the same cycle the wait limit is reached.
    assign expire = inc && (lock_cnt == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory data port between the CPU load/store stage (c_*)
// and the program loader/debug port (l_*).
//   clk, rst                       : clock, asynchronous active-low reset
//   c_/l_valid, c_/l_ready         : request handshake, valid&ready = transfer
//   c_/l_address, _data            : byte address and store data
//   c_/l_write_mode, _read_mode    : ReadWriteModes of the request
//   c_/l_unsigned                  : unsigned load
//   l_lock                         : loader wants exclusive (burst) ownership
//   c_/l_rsp_valid, _rsp_data, _rsp_err : one-cycle registered response
//   mem_*                          : memory pins, driven only during a transfer
//   mem_data_output                : combinational read data from memory
//   owner                          : ArbOwner of the current-cycle transfer
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_valid,
    output logic        c_ready,
    input  logic [31:0] c_address,
    input  logic [31:0] c_data,
    input  logic [2:0]  c_write_mode,
    input  logic [2:0]  c_read_mode,
    input  logic        c_unsigned,
    input  logic        l_valid,
    output logic        l_ready,
    input  logic [31:0] l_address,
    input  logic [31:0] l_data,
    input  logic [2:0]  l_write_mode,
    input  logic [2:0]  l_read_mode,
    input  logic        l_unsigned,
    input  logic        l_lock,
    output logic        c_rsp_valid,
    output logic [31:0] c_rsp_data,
    output logic        c_rsp_err,
    output logic        l_rsp_valid,
    output logic [31:0] l_rsp_data,
    output logic        l_rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic [2:0]  mem_write_mode,
    output logic [2:0]  mem_read_mode,
    output logic        mem_unsigned_load,
    input  logic [31:0] mem_data_output,
    output logic [1:0]  owner
);

    ArbState     state;
    ArbOwner     last_grant;
    ArbOwner     grant;
    mem_req_t    sel;
    logic        sel_illegal;
    logic [31:0] rsp_data_next;
    logic        lock_inc;
    logic        lock_expire;

    // Grant decision. Ties in ST_ARB go to whoever did not win last; the
    // lock states restrict the port to a single requester. Nothing is
    // granted while reset is held, so no store can land on a reset edge.
    always_comb begin
        grant = OWN_NONE;
        if (rst) begin
            case (state)
                ST_ARB: begin
                    if (c_valid && l_valid) begin
                        grant = (last_grant == OWN_CPU) ? OWN_LDR : OWN_CPU;
                    end else if (c_valid) begin
                        grant = OWN_CPU;
                    end else if (l_valid) begin
                        grant = OWN_LDR;
                    end
                end
                ST_LOCKED: if (l_valid) grant = OWN_LDR;
                ST_YIELD:  if (c_valid) grant = OWN_CPU;
                default:   grant = OWN_NONE;
            endcase
        end
    end

    // Forward the winning request; an illegal mode turns the access into a
    // no-op at the memory but still produces an error response.
    always_comb begin
        sel = '0;
        case (grant)
            OWN_CPU: sel = '{c_address, c_data, c_write_mode, c_read_mode, c_unsigned};
            OWN_LDR: sel = '{l_address, l_data, l_write_mode, l_read_mode, l_unsigned};
            default: sel = '0;
        endcase
        sel_illegal   = is_illegal_mode(sel.write_mode) || is_illegal_mode(sel.read_mode);
        rsp_data_next = (sel_illegal || sel.read_mode == NONE) ? 32'h0 : mem_data_output;
    end

    assign c_ready           = (grant == OWN_CPU);
    assign l_ready           = (grant == OWN_LDR);
    assign owner             = grant;
    assign mem_address       = sel.address;
    assign mem_data          = sel.data;
    assign mem_unsigned_load = sel.unsigned_load;
    assign mem_write_mode    = sel_illegal ? NONE : sel.write_mode;
    assign mem_read_mode     = sel_illegal ? NONE : sel.read_mode;

    assign lock_inc = (state == ST_LOCKED) && c_valid;

    mem_arb_lock_timer #(
        .MAX_LOCK_CYCLES(MAX_LOCK_CYCLES)
    ) u_lock_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!lock_inc),
        .inc    (lock_inc),
        .expire (lock_expire)
    );

    // FSM plus the registered responses. Read data is captured on the
    // transfer edge, which is also when the memory commits a store, so a
    // combined read+write returns the pre-write contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_ARB;
            last_grant  <= OWN_LDR;
            c_rsp_valid <= 1'b0;
            c_rsp_data  <= 32'h0;
            c_rsp_err   <= 1'b0;
            l_rsp_valid <= 1'b0;
            l_rsp_data  <= 32'h0;
            l_rsp_err   <= 1'b0;
        end else begin
            c_rsp_valid <= c_ready;
            c_rsp_err   <= c_ready && sel_illegal;
            c_rsp_data  <= c_ready ? rsp_data_next : 32'h0;
            l_rsp_valid <= l_ready;
            l_rsp_err   <= l_ready && sel_illegal;
            l_rsp_data  <= l_ready ? rsp_data_next : 32'h0;

            if (grant != OWN_NONE) begin
                last_grant <= grant;
            end

            case (state)
                ST_ARB: begin
                    if (grant == OWN_LDR && l_lock) state <= ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (!l_lock) begin
                        state <= ST_ARB;
                    end else if (lock_expire) begin
                        state <= ST_YIELD;
                    end
                end
                ST_YIELD: begin
                    if (c_ready || !c_valid) begin
                        state <= l_lock ? ST_LOCKED : ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a little-endian byte memory
// model on the mem_* pins. A vector table covers single-cycle behaviour;
// hand-written sequences cover reset, the loader lock/yield and reset
// during an in-flight response.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic        valid;
        logic [2:0]  wm;
        logic [2:0]  rm;
        logic [31:0] addr;
        logic [31:0] data;
        logic        uns;
    } req_t;

    typedef struct {
        req_t        c;
        req_t        l;
        logic        lock;
        logic [1:0]  exp_owner;
        logic [2:0]  exp_mwm;
        logic        exp_crv;
        logic        exp_cerr;
        logic [31:0] exp_cdata;
        logic        exp_lrv;
        logic [31:0] exp_ldata;
    } vec_t;

    localparam int NUM_VECS = 14;
    localparam req_t REQ_IDLE = '{1'b0, 3'h0, 3'h0, 32'h0, 32'h0, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        c_valid, c_ready, c_unsigned;
    logic [31:0] c_address, c_data;
    logic [2:0]  c_write_mode, c_read_mode;
    logic        l_valid, l_ready, l_unsigned, l_lock;
    logic [31:0] l_address, l_data;
    logic [2:0]  l_write_mode, l_read_mode;
    logic        c_rsp_valid, c_rsp_err, l_rsp_valid, l_rsp_err;
    logic [31:0] c_rsp_data, l_rsp_data;
    logic [31:0] mem_address, mem_data, mem_data_output;
    logic [2:0]  mem_write_mode, mem_read_mode;
    logic        mem_unsigned_load;
    logic [1:0]  owner;

    logic [7:0]  mem [0:65535] = '{default: 8'h00};
    logic [15:0] wa;
    logic [31:0] rd_word;

    int n_compared   = 0;
    int n_mismatched = 0;

    vec_t       vecs [NUM_VECS];
    logic [1:0] lock_seq [12];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_LOCK_CYCLES(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .c_valid           (c_valid),
        .c_ready           (c_ready),
        .c_address         (c_address),
        .c_data            (c_data),
        .c_write_mode      (c_write_mode),
        .c_read_mode       (c_read_mode),
        .c_unsigned        (c_unsigned),
        .l_valid           (l_valid),
        .l_ready           (l_ready),
        .l_address         (l_address),
        .l_data            (l_data),
        .l_write_mode      (l_write_mode),
        .l_read_mode       (l_read_mode),
        .l_unsigned        (l_unsigned),
        .l_lock            (l_lock),
        .c_rsp_valid       (c_rsp_valid),
        .c_rsp_data        (c_rsp_data),
        .c_rsp_err         (c_rsp_err),
        .l_rsp_valid       (l_rsp_valid),
        .l_rsp_data        (l_rsp_data),
        .l_rsp_err         (l_rsp_err),
        .mem_address       (mem_address),
        .mem_data          (mem_data),
        .mem_write_mode    (mem_write_mode),
        .mem_read_mode     (mem_read_mode),
        .mem_unsigned_load (mem_unsigned_load),
        .mem_data_output   (mem_data_output),
        .owner             (owner)
    );

    // Memory model: little-endian, stores commit on the clock edge.
    assign wa = mem_address[15:0];

    always @(posedge clk) begin
        case (mem_write_mode)
            BYTE: mem[wa] <= mem_data[7:0];
            HALFWORD: begin
                mem[wa]         <= mem_data[7:0];
                mem[wa + 16'd1] <= mem_data[15:8];
            end
            WORD, WORDLEFT, WORDRIGHT: begin
                mem[wa]         <= mem_data[7:0];
                mem[wa + 16'd1] <= mem_data[15:8];
                mem[wa + 16'd2] <= mem_data[23:16];
                mem[wa + 16'd3] <= mem_data[31:24];
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_word = {mem[wa + 16'd3], mem[wa + 16'd2], mem[wa + 16'd1], mem[wa]};
        mem_data_output = 32'h0;
        case (mem_read_mode)
            BYTE:     mem_data_output = mem_unsigned_load ? {24'h0, rd_word[7:0]}
                                                          : {{24{rd_word[7]}}, rd_word[7:0]};
            HALFWORD: mem_data_output = mem_unsigned_load ? {16'h0, rd_word[15:0]}
                                                          : {{16{rd_word[15]}}, rd_word[15:0]};
            WORD, WORDLEFT, WORDRIGHT: mem_data_output = rd_word;
            default:  mem_data_output = 32'h0;
        endcase
    end

    function automatic req_t rq(input logic [2:0] wm, input logic [2:0] rm,
                                input logic [31:0] a, input logic [31:0] d, input logic u);
        return '{1'b1, wm, rm, a, d, u};
    endfunction

    task automatic drive_c(input req_t r);
        c_valid = r.valid; c_write_mode = r.wm; c_read_mode = r.rm;
        c_address = r.addr; c_data = r.data; c_unsigned = r.uns;
    endtask

    task automatic drive_l(input req_t r);
        l_valid = r.valid; l_write_mode = r.wm; l_read_mode = r.rm;
        l_address = r.addr; l_data = r.data; l_unsigned = r.uns;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive_c(v.c);
        drive_l(v.l);
        l_lock = v.lock;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_c(REQ_IDLE);
        drive_l(REQ_IDLE);
        l_lock = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{REQ_IDLE, REQ_IDLE, 1'b0, OWN_NONE, NONE, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{rq(WORD, NONE, 32'h100, 32'hDEADBEEF, 1'b0), rq(WORD, NONE, 32'h0, 32'h80112233, 1'b0),
                     1'b0, OWN_CPU, WORD, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{rq(NONE, WORD, 32'h100, 32'h0, 1'b0), rq(WORD, NONE, 32'h0, 32'h80112233, 1'b0),
                     1'b0, OWN_LDR, WORD, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
        vecs[3]  = '{rq(NONE, WORD, 32'h100, 32'h0, 1'b0), rq(NONE, BYTE, 32'h3, 32'h0, 1'b0),
                     1'b0, OWN_CPU, NONE, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[4]  = '{rq(NONE, WORD, 32'h0, 32'h0, 1'b0), rq(NONE, BYTE, 32'h3, 32'h0, 1'b0),
                     1'b0, OWN_LDR, NONE, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFFFF80};
        vecs[5]  = '{rq(NONE, WORD, 32'h0, 32'h0, 1'b0), rq(NONE, BYTE, 32'h3, 32'h0, 1'b1),
                     1'b0, OWN_CPU, NONE, 1'b1, 1'b0, 32'h80112233, 1'b0, 32'h0};
        vecs[6]  = '{REQ_IDLE, rq(NONE, BYTE, 32'h3, 32'h0, 1'b1),
                     1'b0, OWN_LDR, NONE, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000080};
        vecs[7]  = '{rq(3'h7, NONE, 32'h100, 32'h12345678, 1'b0), REQ_IDLE,
                     1'b0, OWN_CPU, NONE, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[8]  = '{rq(NONE, WORD, 32'h100, 32'h0, 1'b0), REQ_IDLE,
                     1'b0, OWN_CPU, NONE, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[9]  = '{REQ_IDLE, REQ_IDLE, 1'b0, OWN_NONE, NONE, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[10] = '{rq(NONE, 3'h6, 32'h100, 32'h0, 1'b0), rq(NONE, WORD, 32'h100, 32'h0, 1'b0),
                     1'b0, OWN_LDR, NONE, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF};
        vecs[11] = '{rq(NONE, 3'h6, 32'h100, 32'h0, 1'b0), REQ_IDLE,
                     1'b0, OWN_CPU, NONE, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[12] = '{rq(WORD, WORD, 32'h100, 32'hCAFEF00D, 1'b0), REQ_IDLE,
                     1'b0, OWN_CPU, WORD, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[13] = '{rq(NONE, WORD, 32'h100, 32'h0, 1'b0), REQ_IDLE,
                     1'b0, OWN_CPU, NONE, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0};

        lock_seq = '{OWN_CPU, OWN_LDR, OWN_LDR, OWN_LDR, OWN_LDR, OWN_CPU,
                     OWN_LDR, OWN_LDR, OWN_LDR, OWN_CPU, OWN_LDR, OWN_CPU};

        // Reset state: requests present but nothing granted or answered.
        drive_c(rq(NONE, WORD, 32'h100, 32'h0, 1'b0));
        drive_l(rq(WORD, NONE, 32'h200, 32'h55, 1'b0));
        l_lock = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset c_ready", 32'(c_ready), 32'h0);
        checkOutput("reset l_ready", 32'(l_ready), 32'h0);
        checkOutput("reset owner", 32'(owner), 32'(OWN_NONE));
        checkOutput("reset mem_write_mode", 32'(mem_write_mode), 32'(NONE));
        @(posedge clk);
        #1;
        checkOutput("reset c_rsp_valid", 32'(c_rsp_valid), 32'h0);
        checkOutput("reset l_rsp_valid", 32'(l_rsp_valid), 32'h0);
        checkOutput("reset c_rsp_data", c_rsp_data, 32'h0);
        checkOutput("reset l_rsp_err", 32'(l_rsp_err), 32'h0);
        do_reset();

        // Vector table.
        for (int i = 0; i < NUM_VECS; i++) begin
            logic [31:0] exp_addr;
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            exp_addr = (vecs[i].exp_owner == OWN_CPU) ? vecs[i].c.addr :
                       (vecs[i].exp_owner == OWN_LDR) ? vecs[i].l.addr : 32'h0;
            checkOutput($sformatf("vec%0d owner", i), 32'(owner), 32'(vecs[i].exp_owner));
            checkOutput($sformatf("vec%0d c_ready", i), 32'(c_ready), 32'(vecs[i].exp_owner == OWN_CPU));
            checkOutput($sformatf("vec%0d l_ready", i), 32'(l_ready), 32'(vecs[i].exp_owner == OWN_LDR));
            checkOutput($sformatf("vec%0d mem_write_mode", i), 32'(mem_write_mode), 32'(vecs[i].exp_mwm));
            checkOutput($sformatf("vec%0d mem_address", i), mem_address, exp_addr);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d c_rsp_valid", i), 32'(c_rsp_valid), 32'(vecs[i].exp_crv));
            checkOutput($sformatf("vec%0d l_rsp_valid", i), 32'(l_rsp_valid), 32'(vecs[i].exp_lrv));
            if (vecs[i].exp_crv) begin
                checkOutput($sformatf("vec%0d c_rsp_data", i), c_rsp_data, vecs[i].exp_cdata);
                checkOutput($sformatf("vec%0d c_rsp_err", i), 32'(c_rsp_err), 32'(vecs[i].exp_cerr));
            end
            if (vecs[i].exp_lrv) begin
                checkOutput($sformatf("vec%0d l_rsp_data", i), l_rsp_data, vecs[i].exp_ldata);
                checkOutput($sformatf("vec%0d l_rsp_err", i), 32'(l_rsp_err), 32'h0);
            end
        end

        // Loader lock with MAX_LOCK_CYCLES=4: three locked loader transfers
        // per CPU yield, then lock release returns to round-robin.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_c(rq(NONE, WORD, 32'h100, 32'h0, 1'b0));
            drive_l(rq(NONE, WORD, 32'h0, 32'h0, 1'b0));
            l_lock = (i < 10);
            #1;
            checkOutput($sformatf("lock cyc%0d owner", i), 32'(owner), 32'(lock_seq[i]));
            @(posedge clk);
            #1;
            checkOutput($sformatf("lock cyc%0d c_rsp_valid", i), 32'(c_rsp_valid), 32'(lock_seq[i] == OWN_CPU));
            checkOutput($sformatf("lock cyc%0d l_rsp_valid", i), 32'(l_rsp_valid), 32'(lock_seq[i] == OWN_LDR));
        end

        // Reset the cycle after a load transfer; a store held during reset
        // must not reach memory.
        do_reset();
        @(negedge clk);
        drive_c(rq(NONE, WORD, 32'h100, 32'h0, 1'b0));
        #1;
        checkOutput("rstmid owner", 32'(owner), 32'(OWN_CPU));
        @(posedge clk);
        #1;
        checkOutput("rstmid rsp before reset", 32'(c_rsp_valid), 32'h1);
        rst = 1'b0;
        drive_c(rq(WORD, NONE, 32'h100, 32'hBAD0BAD0, 1'b0));
        #1;
        checkOutput("rstmid c_rsp_valid dropped", 32'(c_rsp_valid), 32'h0);
        checkOutput("rstmid c_rsp_data cleared", c_rsp_data, 32'h0);
        checkOutput("rstmid c_ready in reset", 32'(c_ready), 32'h0);
        checkOutput("rstmid mem_write_mode in reset", 32'(mem_write_mode), 32'(NONE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive_c(rq(NONE, WORD, 32'h100, 32'h0, 1'b0));
        drive_l(rq(NONE, WORD, 32'h0, 32'h0, 1'b0));
        #1;
        checkOutput("rstmid first tie owner", 32'(owner), 32'(OWN_CPU));
        @(posedge clk);
        #1;
        checkOutput("rstmid load after reset", c_rsp_data, 32'hCAFEF00D);
        @(negedge clk);
        drive_c(REQ_IDLE);
        drive_l(REQ_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
